lcd_spi_rx: RTL and testbench



---
 rtl/lcd_spi_pkg.sv | 8 +
 rtl/lcd_spi_rx_bytes.sv | 72 +++++++
 rtl/lcd_spi_rx.sv | 118 +++++++++++
 tb/tb_lcd_spi_rx.sv | 118 +++++++++++
 4 files changed

// File: rtl/lcd_spi_pkg.sv
// lcd_spi_pkg: command codes and protocol state encoding for the LCD SPI receiver
package lcd_spi_pkg;
  localparam logic [7:0] CMD_SWRESET = 8'h01;
  localparam logic [7:0] CMD_CASET   = 8'h2A;
  localparam logic [7:0] CMD_RASET   = 8'h2B;
  localparam logic [7:0] CMD_RAMWR   = 8'h2C;
  typedef enum logic [2:0] {S_IDLE, S_CASET, S_RASET, S_RAMWR, S_IGNORE} state_t;
endpackage

// File: rtl/lcd_spi_rx_bytes.sv
// lcd_spi_rx_bytes: pin synchronisers, spi_clk rising-edge detect and byte deserialiser
module lcd_spi_rx_bytes #(
  parameter int C_sync_stages = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_csn,
  input  logic       i_sclk,
  input  logic       i_mosi,
  input  logic       i_dc,
  input  logic       i_resn,
  output logic       o_rx,
  output logic [7:0] o_rx_data,
  output logic       o_rx_dc,
  output logic       o_csn,
  output logic       o_resn,
  output logic       o_byte_valid,
  output logic [7:0] o_byte_data,
  output logic       o_byte_dc
);
  // sync bits: [4]=resn [3]=csn [2]=clk [1]=mosi [0]=dc; reset to idle pin levels
  logic [4:0] r_sync [C_sync_stages];
  logic [4:0] w_s;
  logic       w_rise;
  logic       r_clk_d;
  logic [2:0] r_cnt;
  logic [7:0] r_shift;
  logic       r_full;
  logic       r_dc;
  assign w_s    = r_sync[C_sync_stages-1];
  assign w_rise = w_s[2] & ~r_clk_d;
  assign o_rx      = r_full;
  assign o_rx_data = r_shift;
  assign o_rx_dc   = r_dc;
  assign o_csn     = w_s[3];
  assign o_resn    = w_s[4];
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < C_sync_stages; i++) r_sync[i] <= 5'b11100;
      r_clk_d <= 1'b1;
    end else begin
      r_sync[0] <= {i_resn, i_csn, i_sclk, i_mosi, i_dc};
      for (int i = 1; i < C_sync_stages; i++) r_sync[i] <= r_sync[i-1];
      r_clk_d <= w_s[2];
    end
  end
  always_ff @(posedge clk) begin
    if (reset || !w_s[4]) begin
      r_cnt        <= '0;
      r_shift      <= '0;
      r_full       <= 1'b0;
      r_dc         <= 1'b0;
      o_byte_valid <= 1'b0;
      o_byte_data  <= '0;
      o_byte_dc    <= 1'b0;
    end else begin
      o_byte_valid <= r_full;
      if (r_full) begin
        o_byte_data <= r_shift;
        o_byte_dc   <= r_dc;
      end
      r_full <= 1'b0;
      if (w_s[3]) r_cnt <= '0;
      else if (w_rise) begin
        r_shift <= {r_shift[6:0], w_s[1]};
        r_cnt   <= r_cnt + 3'd1;
        r_full  <= r_cnt == 3'd7;
        if (r_cnt == 3'd7) r_dc <= w_s[0];
      end
    end
  end
endmodule

// File: rtl/lcd_spi_rx.sv
// lcd_spi_rx: ST7789-style SPI receiver decoding CASET/RASET/RAMWR into addressed RGB565 pixel writes
module lcd_spi_rx
  import lcd_spi_pkg::*;
#(
  parameter int C_x_bits      = 8,
  parameter int C_y_bits      = 8,
  parameter int C_x_size      = 240,
  parameter int C_y_size      = 240,
  parameter int C_sync_stages = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                spi_csn,
  input  logic                spi_clk,
  input  logic                spi_mosi,
  input  logic                spi_dc,
  input  logic                spi_resn,
  output logic                byte_valid,
  output logic [7:0]          byte_data,
  output logic                byte_dc,
  output logic                pixel_valid,
  output logic [C_x_bits-1:0] pixel_x,
  output logic [C_y_bits-1:0] pixel_y,
  output logic [15:0]         pixel_color,
  output logic                frame_start
);
  localparam int C_p_bits = C_x_bits > C_y_bits ? C_x_bits : C_y_bits;
  localparam logic [C_x_bits-1:0] C_xe0 = C_x_bits'(C_x_size - 1);
  localparam logic [C_y_bits-1:0] C_ye0 = C_y_bits'(C_y_size - 1);
  logic                w_rx, w_rx_dc, w_csn, w_resn;
  logic [7:0]          w_rx_data;
  logic [15:0]         w_word;
  state_t              r_state;
  logic [1:0]          r_idx;
  logic [7:0]          r_hi;
  logic                r_half;
  logic [C_p_bits-1:0] r_ps;
  logic [C_x_bits-1:0] r_xs, r_xe, r_x;
  logic [C_y_bits-1:0] r_ys, r_ye, r_y;
  lcd_spi_rx_bytes #(.C_sync_stages(C_sync_stages)) u_bytes (
    .clk(clk), .reset(reset), .i_csn(spi_csn), .i_sclk(spi_clk), .i_mosi(spi_mosi),
    .i_dc(spi_dc), .i_resn(spi_resn), .o_rx(w_rx), .o_rx_data(w_rx_data), .o_rx_dc(w_rx_dc),
    .o_csn(w_csn), .o_resn(w_resn), .o_byte_valid(byte_valid), .o_byte_data(byte_data),
    .o_byte_dc(byte_dc)
  );
  assign w_word = {r_hi, w_rx_data};
  always_ff @(posedge clk) begin
    if (reset || !w_resn) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_hi        <= '0;
      r_half      <= 1'b0;
      r_ps        <= '0;
      r_xs        <= '0;
      r_xe        <= C_xe0;
      r_ys        <= '0;
      r_ye        <= C_ye0;
      r_x         <= '0;
      r_y         <= '0;
      pixel_valid <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      pixel_color <= '0;
      frame_start <= 1'b0;
    end else begin
      pixel_valid <= 1'b0;
      frame_start <= 1'b0;
      if (w_csn) r_half <= 1'b0;
      if (w_rx && !w_rx_dc) begin
        // a command always restarts decoding, whatever state we were in
        r_idx   <= '0;
        r_state <= w_rx_data == CMD_CASET ? S_CASET :
                   w_rx_data == CMD_RASET ? S_RASET :
                   w_rx_data == CMD_RAMWR ? S_RAMWR :
                   w_rx_data == CMD_SWRESET ? S_IDLE : S_IGNORE;
        if (w_rx_data == CMD_RAMWR) begin
          r_x         <= r_xs;
          r_y         <= r_ys;
          r_half      <= 1'b0;
          frame_start <= 1'b1;
        end
        if (w_rx_data == CMD_SWRESET) begin
          r_xs <= '0;
          r_xe <= C_xe0;
          r_ys <= '0;
          r_ye <= C_ye0;
        end
      end else if (w_rx && (r_state == S_CASET || r_state == S_RASET)) begin
        r_idx <= r_idx + 2'd1;
        if (r_idx == 2'd0 || r_idx == 2'd2) r_hi <= w_rx_data;
        if (r_idx == 2'd1) r_ps <= w_word[C_p_bits-1:0];
        if (r_idx == 2'd3) begin
          r_state <= S_IDLE;
          if (r_state == S_CASET) begin
            r_xs <= r_ps[C_x_bits-1:0];
            r_xe <= w_word[C_x_bits-1:0];
          end else begin
            r_ys <= r_ps[C_y_bits-1:0];
            r_ye <= w_word[C_y_bits-1:0];
          end
        end
      end else if (w_rx && r_state == S_RAMWR) begin
        if (!r_half) begin
          r_hi   <= w_rx_data;
          r_half <= 1'b1;
        end else begin
          r_half      <= 1'b0;
          pixel_valid <= 1'b1;
          pixel_x     <= r_x;
          pixel_y     <= r_y;
          pixel_color <= w_word;
          r_x         <= r_x == r_xe ? r_xs : r_x + 1'b1;
          if (r_x == r_xe) r_y <= r_y == r_ye ? r_ys : r_y + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_lcd_spi_rx.sv
// tb_lcd_spi_rx: directed SPI stimulus with byte/pixel scoreboards checked by an output monitor
module tb_lcd_spi_rx;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        spi_csn = 1'b1, spi_clk = 1'b1, spi_mosi = 1'b0, spi_dc = 1'b0, spi_resn = 1'b1;
  logic        byte_valid, byte_dc, pixel_valid, frame_start;
  logic [7:0]  byte_data, pixel_x, pixel_y;
  logic [15:0] pixel_color;
  int          n_chk = 0, n_pass = 0, n_pulses = 0, n_frames = 0;
  logic [8:0]  exp_b [$];
  logic [31:0] exp_p [$];
  lcd_spi_rx dut (
    .clk(clk), .reset(reset), .spi_csn(spi_csn), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
    .spi_dc(spi_dc), .spi_resn(spi_resn), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_dc(byte_dc), .pixel_valid(pixel_valid), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .pixel_color(pixel_color), .frame_start(frame_start)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask
  always @(negedge clk) if (!reset) begin
    if (byte_valid || pixel_valid || frame_start) n_pulses++;
    if (frame_start) n_frames++;
    if (byte_valid) begin
      if (exp_b.size() == 0) chk("byte_unexpected", {byte_dc, byte_data}, 9'h1ff);
      else chk("byte", {byte_dc, byte_data}, exp_b.pop_front());
    end
    if (pixel_valid) begin
      chk("pixel_with_byte", byte_valid, 1'b1);
      if (exp_p.size() == 0) chk("pixel_unexpected", {pixel_x, pixel_y, pixel_color}, 32'hffffffff);
      else chk("pixel", {pixel_x, pixel_y, pixel_color}, exp_p.pop_front());
    end
  end
  task automatic send_bits(input logic [7:0] b, input logic d, input int n);
    spi_csn = 1'b0;
    for (int i = 7; i > 7 - n; i--) begin
      @(negedge clk);
      spi_clk = 1'b0;
      spi_mosi = b[i];
      spi_dc = d;
      repeat (2) @(negedge clk);
      spi_clk = 1'b1;
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
  endtask
  task automatic send(input logic [7:0] b, input logic d);
    exp_b.push_back({d, b});
    send_bits(b, d, 8);
  endtask
  task automatic pixel(input logic [15:0] c, input logic [7:0] x, input logic [7:0] y);
    send(c[15:8], 1'b1);
    exp_p.push_back({x, y, c});
    send(c[7:0], 1'b1);
  endtask
  task automatic csn_toggle();
    @(negedge clk);
    spi_csn = 1'b1;
    repeat (8) @(negedge clk);
    spi_csn = 1'b0;
    repeat (2) @(negedge clk);
  endtask
  task automatic drain();
    for (int i = 0; i < 200 && (exp_b.size() != 0 || exp_p.size() != 0); i++) @(negedge clk);
    chk("bytes_drained", exp_b.size(), 0);
    chk("pixels_drained", exp_p.size(), 0);
  endtask
  initial begin
    repeat (5) @(negedge clk);
    reset = 1'b0;
    repeat (100) @(negedge clk);
    chk("idle_outputs", {byte_valid, byte_data, byte_dc, pixel_valid, pixel_x, pixel_y, pixel_color, frame_start}, 0);
    chk("idle_pulses", n_pulses, 0);
    send(8'h2A, 1'b0);
    send(8'h00, 1'b1); send(8'h0A, 1'b1); send(8'h00, 1'b1); send(8'h13, 1'b1);
    send(8'h2C, 1'b0);
    for (int i = 0; i < 20; i++) pixel(16'hF800, 8'(10 + i % 10), 8'(i / 10));
    drain();
    send(8'h2B, 1'b0);
    send(8'h00, 1'b1); send(8'hEE, 1'b1); send(8'h00, 1'b1); send(8'hEF, 1'b1);
    send(8'h2A, 1'b0);
    send(8'h00, 1'b1); send(8'hEE, 1'b1); send(8'h00, 1'b1); send(8'hEF, 1'b1);
    send(8'h2C, 1'b0);
    pixel(16'h1001, 8'd238, 8'd238);
    pixel(16'h1002, 8'd239, 8'd238);
    pixel(16'h1003, 8'd238, 8'd239);
    pixel(16'h1004, 8'd239, 8'd239);
    pixel(16'h1005, 8'd238, 8'd238);
    drain();
    send_bits(8'hFF, 1'b1, 4);
    csn_toggle();
    send(8'h55, 1'b0);
    drain();
    send(8'h2C, 1'b0);
    send(8'hAB, 1'b1);
    csn_toggle();
    pixel(16'h1234, 8'd238, 8'd238);
    drain();
    send(8'h2A, 1'b0);
    send(8'h00, 1'b1); send(8'h05, 1'b1);
    repeat (10) @(negedge clk);
    spi_resn = 1'b0;
    repeat (10) @(negedge clk);
    chk("resn_outputs", {byte_valid, pixel_valid, pixel_x, pixel_y, pixel_color, frame_start}, 0);
    spi_resn = 1'b1;
    repeat (5) @(negedge clk);
    send(8'h2C, 1'b0);
    pixel(16'hBEEF, 8'd0, 8'd0);
    pixel(16'h0001, 8'd1, 8'd0);
    drain();
    chk("frame_starts", n_frames, 4);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
